// File: rtl/bcd_down_timer.sv
// Multi-digit packed-BCD countdown timer with optional auto-reload.
// Counts down one step per enable tick while running and pulses done on reaching zero.
module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                reload_en,
  input  logic                enable,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic                zero,
  output logic [4*DIGITS-1:0] Q
);

  // state  | meaning
  // S_IDLE | count held, enable ignored
  // S_RUN  | count decrements on each enable tick
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int W = 4 * DIGITS;

  state_t         r_state;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_reload;
  logic           r_mode;
  logic           r_done;
  logic [W-1:0]   w_load_clamped;
  logic [W-1:0]   w_q_dec;
  logic           w_q_is_one;
  logic           w_load_zero;

  // Ripple-borrow BCD decrement: zero digits wrap to 9 until the first nonzero digit absorbs it.
  function automatic logic [W-1:0] f_bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  assign w_q_dec     = f_bcd_dec(r_q);
  assign w_q_is_one  = (r_q == W'(1));
  assign w_load_zero = (w_load_clamped == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_q      <= w_load_clamped;
        r_reload <= w_load_clamped;
        r_mode   <= reload_en;
        r_state  <= w_load_zero ? S_IDLE : S_RUN;
      end else if (stop) begin
        r_state <= S_IDLE;
      end else if (r_state == S_RUN && enable) begin
        // Sitting at zero while running only happens in reload mode, one tick after expiry.
        if (r_q == '0) begin
          r_q <= r_reload;
        end else begin
          r_q <= w_q_dec;
          if (w_q_is_one) begin
            r_done <= 1'b1;
            if (!r_mode) r_state <= S_IDLE;
          end
        end
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign zero = (r_q == '0);
  assign Q    = r_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: directed scenarios plus random traffic against a
// decimal-integer reference model of the countdown.
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         reset_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         reload_en;
  logic         enable;
  logic         stop;
  logic         busy;
  logic         done;
  logic         zero;
  logic [W-1:0] Q;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, kept as plain decimal integers
  int m_val, m_rel;
  bit m_mode, m_run, m_done, m_prev_done;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .reload_en  (reload_en),
    .enable     (enable),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .zero       (zero),
    .Q          (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] b);
    int v = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += int'(b[4*i +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Clamp each raw nibble to 9, then read the result as a decimal number.
  function automatic int sanitise(input logic [W-1:0] raw);
    int v = 0;
    int p = 1;
    int d;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(raw[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_val = 0; m_rel = 0; m_mode = 0; m_run = 0; m_done = 0; m_prev_done = 0;
  endtask

  task automatic model_step(input bit ld, input logic [W-1:0] lv, input bit ren,
                            input bit en, input bit st);
    m_prev_done = m_done;
    m_done = 0;
    if (ld) begin
      m_val  = sanitise(lv);
      m_rel  = m_val;
      m_mode = ren;
      m_run  = (m_val != 0);
    end else if (st) begin
      m_run = 0;
    end else if (m_run && en) begin
      if (m_val == 0) begin
        m_val = m_rel;
      end else begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1;
          if (!m_mode) m_run = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("q",    Q,    int2bcd(m_val));
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("zero", zero, (m_val == 0));
    chk("done_twice", m_prev_done & done, 1'b0);
  endtask

  task automatic step(input bit ld, input logic [W-1:0] lv, input bit ren,
                      input bit en, input bit st);
    load = ld; load_value = lv; reload_en = ren; enable = en; stop = st;
    @(posedge clk);
    model_step(ld, lv, ren, en, st);
    #1;
    check_outputs();
    load = 0; enable = 0; stop = 0;
  endtask

  int exp_rel[9] = '{2, 1, 0, 3, 2, 1, 0, 3, 2};

  initial begin
    reset_n = 1'b0; load = 0; load_value = '0; reload_en = 0; enable = 0; stop = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", Q, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_zero", zero, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // plain countdown from 12, no reload
    step(1, 16'h0012, 0, 0, 0);
    for (int t = 1; t <= 12; t++) begin
      step(0, '0, 0, 1, 0);
      chk("cnt_q", bcd2int(Q), 12 - t);
      chk("cnt_done", done, (t == 12));
    end
    chk("cnt_busy_end", busy, 1'b0);
    repeat (3) step(0, '0, 0, 1, 0);
    chk("cnt_hold_zero", Q, 16'h0000);

    // borrow chain
    step(1, 16'h1000, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    chk("borrow_1000", Q, 16'h0999);
    step(1, 16'h0100, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    chk("borrow_0100", Q, 16'h0099);

    // reload mode, period 3
    step(1, 16'h0003, 1, 0, 0);
    for (int t = 0; t < 9; t++) begin
      step(0, '0, 0, 1, 0);
      chk("rel_q", bcd2int(Q), exp_rel[t]);
      chk("rel_done", done, (t == 2 || t == 6));
      chk("rel_busy", busy, 1'b1);
    end

    // sanitising and zero load
    step(1, 16'h00AF, 0, 0, 0);
    chk("sanitise", Q, 16'h0099);
    step(1, 16'h0000, 0, 0, 0);
    chk("zero_load_busy", busy, 1'b0);
    repeat (3) step(0, '0, 0, 1, 0);
    chk("zero_load_done", done, 1'b0);

    // load beats expiry, then stop holds the count
    step(1, 16'h0002, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    chk("prio_pre", Q, 16'h0001);
    step(1, 16'h0005, 0, 1, 0);
    chk("prio_q", Q, 16'h0005);
    chk("prio_done", done, 1'b0);
    step(0, '0, 0, 1, 1);
    chk("stop_q", Q, 16'h0005);
    chk("stop_busy", busy, 1'b0);

    // async reset between edges
    step(1, 16'h0047, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_q", Q, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_zero", zero, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, '0, 0, 1, 0);
    chk("arst_done", done, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit           ld, ren, en, st;
      logic [W-1:0] lv;
      ld  = ($urandom_range(0, 14) == 0);
      lv  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 25)) : W'($urandom);
      ren = $urandom_range(0, 1);
      en  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 39) == 0);
      step(ld, lv, ren, en, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
